fft64_reorder: RTL and testbench

Output reorder buffer placed directly downstream of `fft64` in the one-segment receive path. `fft64` emits each 64-point spectrum in bit-reversed bin order. This block buffers one complete frame in a ping-pong memory and streams it out in natural bin order (0..63), with a bin index and start-of-frame marker, to the demapping stage. It accepts one sample per clock with gaps allowed and never back-pressures.

---
 rtl/fft64_reorder.sv | 115 +++++++++++
 tb/tb_fft64_reorder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft64_reorder.sv
// fft64_reorder: converts bit-reversed 64-point FFT frames to natural bin order.
// One frame is buffered in a ping-pong memory while the previous one is read out.
module fft64_reorder #(
    parameter int DW = 17
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 valid_b,
    input  logic signed [DW-1:0] br,
    input  logic signed [DW-1:0] bi,
    output logic                 valid_o,
    output logic                 sof_o,
    output logic [5:0]           idx_o,
    output logic signed [DW-1:0] yr,
    output logic signed [DW-1:0] yi
);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    function automatic logic [5:0] bitrev6(input logic [5:0] a);
        return {a[0], a[1], a[2], a[3], a[4], a[5]};
    endfunction

    logic [2*DW-1:0] bank0 [64];
    logic [2*DW-1:0] bank1 [64];

    logic [5:0]      wcnt;
    logic            wsel;
    logic            frame_done;
    logic [5:0]      waddr;

    state_t          state;
    logic [5:0]      rcnt;
    logic            rsel;
    logic [2*DW-1:0] rdata;

    assign waddr = bitrev6(wcnt);
    assign rdata = rsel ? bank1[rcnt] : bank0[rcnt];

    // Write-side sample counter, bank toggle and end-of-frame pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wcnt       <= '0;
            wsel       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (valid_b) begin
                wcnt <= wcnt + 6'd1;
                if (wcnt == 6'd63) begin
                    wsel       <= ~wsel;
                    frame_done <= 1'b1;
                end
            end
        end
    end

    // Store each accepted sample at its bit-reversed address in the write bank.
    always_ff @(posedge CLK) begin
        if (!RST && valid_b) begin
            if (wsel)
                bank1[waddr] <= {br, bi};
            else
                bank0[waddr] <= {br, bi};
        end
    end

    // Read FSM: issues addresses 0..63 of the filled bank and registers the read data.
    // wsel has already toggled when frame_done is seen, so ~wsel is the bank just filled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            rcnt    <= '0;
            rsel    <= 1'b0;
            valid_o <= 1'b0;
            sof_o   <= 1'b0;
            idx_o   <= '0;
            yr      <= '0;
            yi      <= '0;
        end else begin
            valid_o <= 1'b0;
            sof_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_done) begin
                        rsel  <= ~wsel;
                        rcnt  <= '0;
                        state <= READ;
                    end
                end
                READ: begin
                    valid_o <= 1'b1;
                    sof_o   <= (rcnt == 6'd0);
                    idx_o   <= rcnt;
                    yr      <= $signed(rdata[2*DW-1:DW]);
                    yi      <= $signed(rdata[DW-1:0]);
                    rcnt    <= rcnt + 6'd1;
                    if (rcnt == 6'd63) begin
                        if (frame_done) begin
                            rsel <= ~wsel;
                            rcnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft64_reorder.sv
// tb_fft64_reorder: directed bench for the bit-reversed to natural-order reorder buffer.
module tb_fft64_reorder;

    localparam int DW = 17;

    logic                 clk;
    logic                 rst;
    logic                 valid_b;
    logic signed [DW-1:0] br;
    logic signed [DW-1:0] bi;
    logic                 valid_o;
    logic                 sof_o;
    logic [5:0]           idx_o;
    logic signed [DW-1:0] yr;
    logic signed [DW-1:0] yi;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int e_cyc = 0;
    int e0    = 0;

    logic signed [DW-1:0] q_yr [$];
    logic signed [DW-1:0] q_yi [$];
    logic [5:0]           q_idx [$];
    logic                 q_sof [$];
    int                   q_cyc [$];

    fft64_reorder #(.DW(DW)) dut (
        .CLK     (clk),
        .RST     (rst),
        .valid_b (valid_b),
        .br      (br),
        .bi      (bi),
        .valid_o (valid_o),
        .sof_o   (sof_o),
        .idx_o   (idx_o),
        .yr      (yr),
        .yi      (yi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so output timing can be related to input timing.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid output sample away from the active edge.
    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            q_yr.push_back(yr);
            q_yi.push_back(yi);
            q_idx.push_back(idx_o);
            q_sof.push_back(sof_o);
            q_cyc.push_back(cyc);
        end
    end

    function automatic int brev(input int m);
        int r = 0;
        for (int i = 0; i < 6; i++)
            if ((m >> i) & 1) r = r + (1 << (5 - i));
        return r;
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        q_yr.delete();
        q_yi.delete();
        q_idx.delete();
        q_sof.delete();
        q_cyc.delete();
    endtask

    task automatic send_sample(input int r, input int i);
        logic [31:0] rv;
        logic [31:0] iv;
        rv = r;
        iv = i;
        @(negedge clk);
        valid_b = 1'b1;
        br      = rv[DW-1:0];
        bi      = iv[DW-1:0];
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        valid_b = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    // Ramp frame br = off+n, bi = -(off+n); optional low cycle after every two samples.
    task automatic send_frame(input int off, input bit gap);
        for (int n = 0; n < 64; n++) begin
            if (gap && n > 0 && (n % 2) == 0) begin
                @(negedge clk);
                valid_b = 1'b0;
            end
            send_sample(off + n, -(off + n));
        end
        e_cyc = cyc + 1;
    endtask

    task automatic check_ramp(input string tag, input int base, input int off);
        for (int m = 0; m < 64; m++) begin
            check({tag, "_idx"}, q_idx[base + m], m);
            check({tag, "_yr"}, q_yr[base + m], off + brev(m));
            check({tag, "_yi"}, q_yi[base + m], -(off + brev(m)));
            check({tag, "_sof"}, q_sof[base + m], (m == 0) ? 1 : 0);
        end
    endtask

    initial begin
        rst     = 1'b1;
        valid_b = 1'b0;
        br      = '0;
        bi      = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_valid", valid_o, 0);
        check("rst_sof", sof_o, 0);
        check("rst_idx", idx_o, 0);
        check("rst_yr", yr, 0);
        check("rst_yi", yi, 0);

        // Ramp frame, continuous input
        clear_q();
        send_frame(0, 1'b0);
        idle(80);
        check("ramp_count", q_yr.size(), 64);
        if (q_yr.size() == 64) begin
            check("ramp_first", q_cyc[0], e_cyc + 2);
            check("ramp_last", q_cyc[63], e_cyc + 65);
            check("ramp_bin1", q_yr[1], 32);
            check("ramp_bin2", q_yr[2], 16);
            check("ramp_bin3", q_yr[3], 48);
            check("ramp_bin63", q_yr[63], 63);
            check("ramp_bin63_i", q_yi[63], -63);
            check_ramp("ramp", 0, 0);
        end

        // Three back-to-back frames
        clear_q();
        send_frame(0, 1'b0);
        e0 = e_cyc;
        send_frame(100, 1'b0);
        send_frame(200, 1'b0);
        idle(80);
        check("b2b_count", q_yr.size(), 192);
        if (q_yr.size() == 192) begin
            check("b2b_first", q_cyc[0], e0 + 2);
            check("b2b_last", q_cyc[191], e0 + 2 + 191);
            check("b2b_sof64", q_sof[64], 1);
            check("b2b_sof128", q_sof[128], 1);
            check("b2b_f1_bin1", q_yr[65], 132);
            check("b2b_f2_bin3", q_yr[131], 248);
            for (int f = 0; f < 3; f++) check_ramp("b2b", 64 * f, 100 * f);
        end

        // Gapped input
        clear_q();
        send_frame(0, 1'b1);
        idle(80);
        check("gap_count", q_yr.size(), 64);
        if (q_yr.size() == 64) begin
            check("gap_first", q_cyc[0], e_cyc + 2);
            check("gap_last", q_cyc[63], e_cyc + 65);
            check_ramp("gap", 0, 0);
        end

        // Reset mid-frame, then a full frame
        clear_q();
        for (int n = 0; n < 40; n++) send_sample(500 + n, 7);
        @(negedge clk);
        valid_b = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_valid", valid_o, 0);
        send_frame(0, 1'b0);
        idle(80);
        check("mrst_count", q_yr.size(), 64);
        if (q_yr.size() == 64) begin
            check("mrst_first", q_cyc[0], e_cyc + 2);
            check_ramp("mrst", 0, 0);
        end

        // Extreme values at input position 5 -> bin 40
        clear_q();
        for (int n = 0; n < 64; n++) begin
            if (n == 5) send_sample(-65536, 65535);
            else send_sample(0, 0);
        end
        idle(80);
        check("ext_count", q_yr.size(), 64);
        if (q_yr.size() == 64) begin
            check("ext_yr40", q_yr[40], -65536);
            check("ext_yi40", q_yi[40], 65535);
            check("ext_idx40", q_idx[40], 40);
            check("ext_yr5", q_yr[5], 0);
            check("ext_yi0", q_yi[0], 0);
        end

        // Partial frame is never emitted
        clear_q();
        for (int n = 0; n < 30; n++) send_sample(n, -n);
        idle(500);
        check("partial_count", q_yr.size(), 0);
        check("partial_valid", valid_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
